capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl_if.sv | 30 +++
 rtl/capture_ctrl.sv | 109 ++++++++++
 tb/tb_capture_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_if.sv
// Capture control bundle between sampler/trigger logic and the capture FSM.
// The master side drives strobes and config; the slave side returns RAM control.
interface capture_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              wrt_smpl;
  logic              run;
  logic              triggered;
  logic [ADDR_W-1:0] trig_pos;
  logic              capture_done_clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              armed;
  logic              capture_done;
  logic [ADDR_W-1:0] trace_end;

  modport master (
    output wrt_smpl, run, triggered,
    output trig_pos, capture_done_clr,
    input  we, waddr, armed,
    input  capture_done, trace_end
  );

  modport slave (
    input  wrt_smpl, run, triggered,
    input  trig_pos, capture_done_clr,
    output we, waddr, armed,
    output capture_done, trace_end
  );
endinterface

// File: rtl/capture_ctrl.sv
// Sample-capture FSM: fills a circular sample RAM, arms on enough
// pre-trigger history, stores trig_pos post-trigger samples, then freezes.
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9
) (
  input logic           clk,
  input logic           rst_n,
  capture_ctrl_if.slave c
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    POST_TRIG,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   ENT  = (ADDR_W+1)'(ENTRIES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

  state_t            state, state_d;
  logic [ADDR_W:0]   smpl_cnt, smpl_nxt, arm_sum;
  logic [ADDR_W-1:0] post_cnt, post_inc;
  logic [ADDR_W-1:0] tp, waddr_inc, waddr_dec;
  logic              active, trig_go, post_last;

  assign tp        = (c.trig_pos > LAST) ? LAST : c.trig_pos;
  assign active    = (state == CAPTURE) || (state == POST_TRIG);
  assign waddr_inc = (c.waddr == LAST) ? '0 : c.waddr + 1'b1;
  assign waddr_dec = (c.waddr == '0) ? LAST : c.waddr - 1'b1;
  assign post_inc  = post_cnt + 1'b1;
  assign post_last = c.we && (post_inc == tp);
  assign trig_go   = (state == CAPTURE) && c.armed && c.triggered;

  // Saturating pre-trigger count; arming looks at the post-write value
  always_comb begin
    smpl_nxt = smpl_cnt;
    if (state == CAPTURE && c.we && smpl_cnt < ENT)
      smpl_nxt = smpl_cnt + 1'b1;
  end

  assign arm_sum = smpl_nxt + {1'b0, tp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (c.run && !c.capture_done)
          state_d = CAPTURE;
      CAPTURE:
        if (!c.run)       state_d = IDLE;
        else if (trig_go) state_d = (tp == '0) ? DONE : POST_TRIG;
      POST_TRIG:
        if (!c.run)         state_d = IDLE;
        else if (post_last) state_d = DONE;
      DONE:
        if (c.capture_done_clr)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    c.we = c.wrt_smpl && active;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c.waddr        <= '0;
      c.armed        <= 1'b0;
      c.capture_done <= 1'b0;
      c.trace_end    <= '0;
      smpl_cnt       <= '0;
      post_cnt       <= '0;
    end else begin
      c.capture_done <= (state_d == DONE);
      c.armed <= (state_d == CAPTURE || state_d == POST_TRIG) &&
                 (c.armed || (state == CAPTURE && arm_sum >= ENT));
      unique case (1'b1)
        (state == IDLE && state_d == CAPTURE): begin
          c.waddr  <= '0;
          smpl_cnt <= '0;
          post_cnt <= '0;
        end
        c.we: c.waddr <= waddr_inc;
        default: ;
      endcase
      if (state == CAPTURE)
        smpl_cnt <= smpl_nxt;
      unique case (1'b1)
        trig_go:                     post_cnt <= '0;
        (state == POST_TRIG && c.we): post_cnt <= post_inc;
        default: ;
      endcase
      // A sample written alongside the trigger is the last pre-trigger one
      if (state_d == DONE && state == CAPTURE)
        c.trace_end <= c.we ? c.waddr : waddr_dec;
      else if (state_d == DONE && state == POST_TRIG)
        c.trace_end <= c.waddr;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ENTRIES=8.
// Write count and last written address are tracked on the clock edge.
module tb_capture_ctrl;

  localparam int AW = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   wr_cnt;
  int   w0;
  int   last_wa;

  capture_ctrl_if #(.ADDR_W(AW)) c ();

  capture_ctrl #(
    .ENTRIES(8),
    .ADDR_W (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .c    (c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (c.we) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= int'(c.waddr);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic ws, input logic tr, input logic cl);
    c.wrt_smpl         = ws;
    c.triggered        = tr;
    c.capture_done_clr = cl;
    @(posedge clk);
    #1;
    c.wrt_smpl         = 1'b0;
    c.triggered        = 1'b0;
    c.capture_done_clr = 1'b0;
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    wr_cnt  = 0;
    last_wa = -1;
    c.wrt_smpl         = 1'b0;
    c.run              = 1'b0;
    c.triggered        = 1'b0;
    c.trig_pos         = '0;
    c.capture_done_clr = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_we", int'(c.we), 0);
    check("rst_waddr", int'(c.waddr), 0);
    check("rst_armed", int'(c.armed), 0);
    check("rst_done", int'(c.capture_done), 0);
    check("rst_tend", int'(c.trace_end), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 1'b0);
    check("idle_nowrite", wr_cnt, 0);

    // basic capture: tp=3, trigger after 6th write
    c.run      = 1'b1;
    c.trig_pos = AW'(3);
    cyc(1'b0, 1'b0, 1'b0);
    w0 = wr_cnt;
    writes(4);
    check("s1_armed4", int'(c.armed), 0);
    writes(1);
    check("s1_armed5", int'(c.armed), 1);
    check("s1_waddr5", int'(c.waddr), 5);
    writes(1);
    cyc(1'b0, 1'b1, 1'b0);
    check("s1_pre_writes", wr_cnt - w0, 6);
    w0 = wr_cnt;
    writes(2);
    check("s1_notdone", int'(c.capture_done), 0);
    writes(1);
    check("s1_done", int'(c.capture_done), 1);
    check("s1_tend", int'(c.trace_end), 0);
    check("s1_waddr", int'(c.waddr), 1);
    check("s1_post_writes", wr_cnt - w0, 3);
    check("s1_armed_off", int'(c.armed), 0);
    w0 = wr_cnt;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    check("s1_frozen_wr", wr_cnt - w0, 0);
    check("s1_frozen_addr", int'(c.waddr), 1);
    check("s1_hold_done", int'(c.capture_done), 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("s1_clr", int'(c.capture_done), 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("s1_restart_addr", int'(c.waddr), 0);

    // early trigger is ignored
    w0 = wr_cnt;
    writes(2);
    cyc(1'b0, 1'b1, 1'b0);
    check("s2_early_armed", int'(c.armed), 0);
    check("s2_early_done", int'(c.capture_done), 0);
    writes(3);
    check("s2_armed", int'(c.armed), 1);
    check("s2_waddr", int'(c.waddr), 5);
    check("s2_writes", wr_cnt - w0, 5);
    c.run = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check("s2_abort_armed", int'(c.armed), 0);
    w0 = wr_cnt;
    cyc(1'b1, 1'b0, 1'b0);
    check("s2_abort_wr", wr_cnt - w0, 0);

    // tp=0: done on trigger, trace_end = waddr-1
    c.run      = 1'b1;
    c.trig_pos = AW'(0);
    cyc(1'b0, 1'b0, 1'b0);
    writes(7);
    check("s3_armed7", int'(c.armed), 0);
    writes(3);
    check("s3_armed10", int'(c.armed), 1);
    cyc(1'b0, 1'b1, 1'b0);
    check("s3_done", int'(c.capture_done), 1);
    check("s3_tend", int'(c.trace_end), 1);
    check("s3_waddr", int'(c.waddr), 2);
    w0 = wr_cnt;
    cyc(1'b1, 1'b0, 1'b0);
    check("s3_nowrite", wr_cnt - w0, 0);
    cyc(1'b0, 1'b0, 1'b1);

    // trig_pos=12 clamps to 7
    c.trig_pos = AW'(12);
    cyc(1'b0, 1'b0, 1'b0);
    writes(1);
    check("s4_armed1", int'(c.armed), 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("s4_clr_noeff", int'(c.armed), 1);
    cyc(1'b0, 1'b1, 1'b0);
    w0 = wr_cnt;
    writes(6);
    check("s4_notdone", int'(c.capture_done), 0);
    writes(1);
    check("s4_done", int'(c.capture_done), 1);
    check("s4_post_writes", wr_cnt - w0, 7);
    check("s4_tend", int'(c.trace_end), 7);
    check("s4_waddr", int'(c.waddr), 0);
    cyc(1'b0, 1'b0, 1'b1);

    // run dropped in POST_TRIG
    c.trig_pos = AW'(3);
    cyc(1'b0, 1'b0, 1'b0);
    writes(5);
    cyc(1'b0, 1'b1, 1'b0);
    writes(1);
    c.run = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check("s5_armed", int'(c.armed), 0);
    check("s5_done", int'(c.capture_done), 0);
    c.wrt_smpl = 1'b1;
    #1;
    check("s5_we", int'(c.we), 0);
    w0 = wr_cnt;
    cyc(1'b1, 1'b0, 1'b0);
    check("s5_nowrite", wr_cnt - w0, 0);
    c.run = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("s5_restart", int'(c.waddr), 0);
    writes(1);
    check("s5_first_addr", last_wa, 0);

    // async reset mid POST_TRIG
    writes(4);
    cyc(1'b0, 1'b1, 1'b0);
    writes(1);
    c.wrt_smpl = 1'b1;
    #2;
    check("s6_pre_we", int'(c.we), 1);
    rst_n = 1'b0;
    #1;
    check("s6_we", int'(c.we), 0);
    check("s6_waddr", int'(c.waddr), 0);
    check("s6_armed", int'(c.armed), 0);
    check("s6_tend", int'(c.trace_end), 0);
    check("s6_done", int'(c.capture_done), 0);
    c.wrt_smpl = 1'b0;
    c.run      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    check("s6_idle_wr", wr_cnt - w0, 0);
    c.run = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    writes(1);
    check("s6_resume", int'(c.waddr), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
